fb_loader: RTL and testbench
============================

Name: fb_loader

Overview:
- Write-side companion to the panel scan controller: parses a byte-command stream (from UART/SPI front end) into framebuffer write cycles (waddr/din/we).
- Sits between the host byte interface and the framebuffer write port; the scan controller keeps the read ports.
- Supports clear-to-colour, single-pixel write and packed-pixel burst.

Parameters:
- ADDR_W, 12, framebuffer address width; address = {half_sel, row[4:0], col[5:0]}; fill covers 2**ADDR_W entries.
- PIX_W, 4, pixel width; fixed at 4 because the burst format packs two pixels per byte.
- TIMEOUT, 1024, idle cycles allowed between bytes of one command (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_data  in  8  command/argument byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a byte; transfer when in_valid && in_ready at rising edge
- fb_waddr  out  ADDR_W  framebuffer write address
- fb_din  out  PIX_W  framebuffer write data
- fb_we  out  1  framebuffer write enable (ce tied high at framebuffer)
- busy  out  1  high whenever state != IDLE
- cmd_err  out  1  one-cycle pulse on unknown opcode or timeout abort

Behaviour:
- Reset: in_ready=1, fb_waddr=0, fb_din=0, fb_we=0, busy=0, cmd_err=0, state=IDLE, counters=0. Asserting rst mid-command aborts immediately; no further writes; partial command discarded.
- All outputs registered. A write issued at edge N (fb_we=1 after N) lands in the framebuffer at edge N+1.
- States: IDLE, ARG0, ARG1, ARG2, FILL, BURST_HI, BURST_LO.
- IDLE: accepted byte is an opcode.
  - 0x01 FILL -> ARG0.
  - 0x02 PIXEL -> ARG0.
  - 0x03 BURST -> ARG0.
  - Any other value -> cmd_err=1 for one cycle; stay IDLE.
- FILL: ARG0 byte = colour (low nibble used).
  - On acceptance: fb_we=1, fb_waddr=0, fb_din=colour, in_ready=0, state FILL.
  - Each following cycle: fb_waddr+1. Exactly 2**ADDR_W consecutive write cycles (0..4095).
  - After the write with fb_waddr = all-ones: fb_we=0, in_ready=1, IDLE.
- PIXEL: ARG0 = {colour[3:0], addr[11:8]}; ARG1 = addr[7:0].
  - On ARG1 acceptance: one write cycle with fb_waddr=addr, fb_din=colour; then IDLE.
  - in_ready stays 1 throughout.
- BURST: ARG0 = {4'b0, start[11:8]} (upper nibble ignored); ARG1 = start[7:0]; ARG2 = count N of bytes, 0 means 256. Then state BURST_HI.
  - BURST_HI: accepted byte b -> write b[7:4] at ptr; in_ready=0; state BURST_LO.
  - BURST_LO: write b[3:0] at ptr+1; ptr+=2; in_ready=1; remaining-1; when remaining reaches 0 -> IDLE, else BURST_HI.
  - Throughput: one byte per 2 cycles maximum.
  - ptr arithmetic modulo 2**ADDR_W: 4095 wraps to 0, including the hi/lo pair straddling 4095/0.
- in_valid low in any ARGx/BURST_HI state: block waits indefinitely; no writes (without optional feature).
- fb_we is never high in IDLE, ARGx, or while waiting for a byte.

Optional Feature:
- Macro FB_LOADER_TIMEOUT_EN.
- Defined: cycle counter runs in ARG0/ARG1/ARG2/BURST_HI while no byte is accepted; resets on each acceptance. Reaching TIMEOUT -> cmd_err pulse, return to IDLE, no write for the pending command. Writes already issued in a burst are kept.
- Undefined: counter absent; block waits forever; cmd_err pulses only on unknown opcode.

Test Plan:
- Reset mid-FILL at cycle 100: all outputs return to reset values; no fb_we after rst; next opcode 0x02 is accepted normally.
- Bytes 0x02, 0xA7, 0x3C -> one cycle fb_we=1, fb_waddr=0x73C, fb_din=0xA; in_ready never drops.
- Bytes 0x01, 0x05 -> 4096 consecutive writes, fb_din=5, addresses 0..4095; in_ready=0 for exactly 4096 cycles; busy falls afterwards.
- Bytes 0x03, 0x0F, 0xFF, 0x02, 0x12, 0x34 with in_valid held high -> writes (0xFFF,1), (0x000,2), (0x001,3), (0x002,4) on 4 consecutive cycles; in_ready pattern 1,0,1,0; then IDLE.
- Opcode 0x7E -> cmd_err pulse of exactly 1 cycle; no write; the following 0x02 command executes.
- FB_LOADER_TIMEOUT_EN, TIMEOUT=16: bytes 0x02, 0x11, then silence -> cmd_err after 16 idle cycles; no write; IDLE.

Source files
------------

// File: rtl/fb_loader.sv
// fb_loader: turns a host byte-command stream into framebuffer write cycles.
// Commands: 0x01 fill-to-colour, 0x02 single pixel, 0x03 packed-pixel burst.
// Optional build macro FB_LOADER_TIMEOUT_EN aborts a command that stalls
// between bytes for TIMEOUT cycles. It reports the abort on cmd_err.
module fb_loader #(
    parameter int ADDR_W  = 12,
    parameter int PIX_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [PIX_W-1:0]  fb_din,
    output logic              fb_we,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        IDLE, ARG0, ARG1, ARG2, FILL, BURST_HI, BURST_LO
    } state_t;

    typedef enum logic [1:0] {
        OP_FILL, OP_PIXEL, OP_BURST
    } op_t;

    state_t            state, state_n;
    op_t               op, op_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [8:0]        remaining, remaining_n;
    logic [PIX_W-1:0]  hold, hold_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [PIX_W-1:0]  din_n;
    logic              we_n, err_n, ready_n, busy_n;
    logic              accept;

`ifdef FB_LOADER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    logic [TIMER_W-1:0] timer, timer_n;
`endif

    assign accept = in_valid && in_ready;

    // Next-state, datapath and registered-output values for the command parser
    always_comb begin
        state_n     = state;
        op_n        = op;
        ptr_n       = ptr;
        remaining_n = remaining;
        hold_n      = hold;
        waddr_n     = fb_waddr;
        din_n       = fb_din;
        we_n        = 1'b0;
        err_n       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (in_data)
                        8'h01: begin op_n = OP_FILL;  state_n = ARG0; end
                        8'h02: begin op_n = OP_PIXEL; state_n = ARG0; end
                        8'h03: begin op_n = OP_BURST; state_n = ARG0; end
                        default: err_n = 1'b1;
                    endcase
                end
            end
            ARG0: begin
                if (accept) begin
                    if (op == OP_FILL) begin
                        we_n    = 1'b1;
                        waddr_n = '0;
                        din_n   = in_data[3:0];
                        state_n = FILL;
                    end else begin
                        hold_n  = in_data[7:4];
                        ptr_n   = ADDR_W'({in_data[3:0], 8'h00});
                        state_n = ARG1;
                    end
                end
            end
            ARG1: begin
                if (accept) begin
                    ptr_n = {ptr[ADDR_W-1:8], in_data};
                    if (op == OP_PIXEL) begin
                        we_n    = 1'b1;
                        waddr_n = {ptr[ADDR_W-1:8], in_data};
                        din_n   = hold;
                        state_n = IDLE;
                    end else begin
                        state_n = ARG2;
                    end
                end
            end
            ARG2: begin
                if (accept) begin
                    remaining_n = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    state_n     = BURST_HI;
                end
            end
            FILL: begin
                if (fb_waddr == '1) begin
                    state_n = IDLE;
                end else begin
                    we_n    = 1'b1;
                    waddr_n = fb_waddr + ADDR_W'(1);
                end
            end
            BURST_HI: begin
                if (accept) begin
                    we_n    = 1'b1;
                    waddr_n = ptr;
                    din_n   = in_data[7:4];
                    hold_n  = in_data[3:0];
                    state_n = BURST_LO;
                end
            end
            BURST_LO: begin
                we_n        = 1'b1;
                waddr_n     = ptr + ADDR_W'(1);
                din_n       = hold;
                ptr_n       = ptr + ADDR_W'(2);
                remaining_n = remaining - 9'd1;
                state_n     = (remaining == 9'd1) ? IDLE : BURST_HI;
            end
            default: state_n = IDLE;
        endcase
`ifdef FB_LOADER_TIMEOUT_EN
        timer_n = '0;
        if ((state == ARG0 || state == ARG1 || state == ARG2 || state == BURST_HI) && !accept) begin
            if (timer == TIMER_W'(TIMEOUT - 1)) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end else begin
                timer_n = timer + TIMER_W'(1);
            end
        end
`endif
        ready_n = !(state_n == FILL || state_n == BURST_LO);
        busy_n  = (state_n != IDLE);
    end

    // State, datapath and output registers; reset abandons any partial command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_FILL;
            ptr       <= '0;
            remaining <= '0;
            hold      <= '0;
            fb_waddr  <= '0;
            fb_din    <= '0;
            fb_we     <= 1'b0;
            cmd_err   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef FB_LOADER_TIMEOUT_EN
            timer     <= '0;
`endif
        end else begin
            state     <= state_n;
            op        <= op_n;
            ptr       <= ptr_n;
            remaining <= remaining_n;
            hold      <= hold_n;
            fb_waddr  <= waddr_n;
            fb_din    <= din_n;
            fb_we     <= we_n;
            cmd_err   <= err_n;
            in_ready  <= ready_n;
            busy      <= busy_n;
`ifdef FB_LOADER_TIMEOUT_EN
            timer     <= timer_n;
`endif
        end
    end

endmodule

// File: tb/tb_fb_loader.sv
// tb_fb_loader: drives random and directed command streams into fb_loader.
// Expected writes come from decoding each command at the command level.
// Decoded writes go into a queue, which a negedge monitor consumes in order.
module tb_fb_loader;

`ifdef FB_LOADER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] fb_waddr;
    logic [3:0]  fb_din;
    logic        fb_we;
    logic        busy;
    logic        cmd_err;

    fb_loader #(.ADDR_W(12), .PIX_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .fb_waddr(fb_waddr), .fb_din(fb_din),
        .fb_we(fb_we), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    logic [15:0] expQ[$];
    int errCycles = 0, expErr = 0, readyLow = 0;
    int wrCount = 0, firstWr = -1, lastWr = -1, cyc = 0;
    int gapMax = 0;
    int fillsDone = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Free-running cycle count used to time-stamp writes
    always @(posedge clk) cyc++;

    // Monitor: every write must match the head of the expected-write queue
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_err) errCycles++;
            if (!in_ready) readyLow++;
            if (fb_we) begin
                wrCount++;
                if (firstWr < 0) firstWr = cyc;
                lastWr = cyc;
                checkOutput("write pending", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) checkOutput("write addr/data", {fb_waddr, fb_din}, expQ.pop_front());
            end
        end
    end

    task automatic resetCounters();
        readyLow = 0; wrCount = 0; firstWr = -1; lastWr = -1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int n;
        if (gapMax > 0) repeat ($urandom_range(gapMax, 0)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) checkOutput("in_ready wait timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while ((busy || expQ.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) checkOutput("drain timeout", n, 0);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, " err pulses"}, errCycles, expErr);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " in_ready"}, in_ready, 1);
    endtask

    task automatic doFill(input logic [3:0] c);
        for (int i = 0; i < 4096; i++) expQ.push_back({i[11:0], c});
        applyStimulus(8'h01);
        applyStimulus({4'($urandom_range(15)), c});
    endtask

    task automatic doPixel(input logic [11:0] a, input logic [3:0] c);
        expQ.push_back({a, c});
        applyStimulus(8'h02);
        applyStimulus({c, a[11:8]});
        applyStimulus(a[7:0]);
    endtask

    task automatic doBurst(input logic [11:0] start, input int n, input logic [7:0] first, input logic [7:0] second, input bit randomBytes);
        logic [7:0] data[$];
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            if (randomBytes) data.push_back(8'($urandom));
            else data.push_back(i == 0 ? first : second);
        end
        a = start;
        foreach (data[i]) begin
            expQ.push_back({a, data[i][7:4]});
            a = a + 12'd1;
            expQ.push_back({a, data[i][3:0]});
            a = a + 12'd1;
        end
        applyStimulus(8'h03);
        applyStimulus({4'($urandom_range(15)), start[11:8]});
        applyStimulus(start[7:0]);
        applyStimulus(8'(n));
        foreach (data[i]) applyStimulus(data[i]);
    endtask

    task automatic doBad(input logic [7:0] opc);
        expErr++;
        applyStimulus(opc);
    endtask

    // Watchdog so the run always ends on its own
    initial begin
        #3_000_000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Main sequence
    initial begin
        logic [7:0] opc;
        int r, n;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset fb_waddr", fb_waddr, 0);
        checkOutput("reset fb_din", fb_din, 0);
        checkOutput("reset fb_we", fb_we, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset cmd_err", cmd_err, 0);
        rst = 1'b0;

        $display("[TB] single pixel");
        resetCounters();
        doPixel(12'h73C, 4'hA);
        waitIdle();
        checkOutput("pixel write count", wrCount, 1);
        checkOutput("pixel in_ready low cycles", readyLow, 0);
        checkQuiet("pixel");

        $display("[TB] fill");
        resetCounters();
        doFill(4'h5);
        waitIdle();
        checkOutput("fill write count", wrCount, 4096);
        checkOutput("fill contiguous", lastWr - firstWr, 4095);
        checkOutput("fill in_ready low cycles", readyLow, 4096);
        checkQuiet("fill");

        $display("[TB] burst straddling the top address");
        resetCounters();
        doBurst(12'hFFF, 2, 8'h12, 8'h34, 1'b0);
        waitIdle();
        checkOutput("burst write count", wrCount, 4);
        checkOutput("burst contiguous", lastWr - firstWr, 3);
        checkOutput("burst in_ready low cycles", readyLow, 2);
        checkQuiet("burst");

        $display("[TB] unknown opcode");
        resetCounters();
        doBad(8'h7E);
        waitIdle();
        checkOutput("bad opcode writes", wrCount, 0);
        checkQuiet("bad opcode");
        resetCounters();
        doPixel(12'h015, 4'h9);
        waitIdle();
        checkOutput("pixel after bad opcode", wrCount, 1);

        $display("[TB] reset during fill");
        doFill(4'hC);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("mid reset in_ready", in_ready, 1);
        checkOutput("mid reset fb_waddr", fb_waddr, 0);
        checkOutput("mid reset fb_din", fb_din, 0);
        checkOutput("mid reset fb_we", fb_we, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset cmd_err", cmd_err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        resetCounters();
        repeat (5) @(negedge clk);
        checkOutput("writes after reset", wrCount, 0);
        doPixel(12'hABC, 4'h3);
        waitIdle();
        checkOutput("pixel after reset", wrCount, 1);
        checkQuiet("after reset");

`ifdef FB_LOADER_TIMEOUT_EN
        $display("[TB] stalled command timeout");
        resetCounters();
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        expErr++;
        repeat (TO + 4) @(negedge clk);
        checkOutput("timeout writes", wrCount, 0);
        checkQuiet("timeout");
`endif

        $display("[TB] random commands");
        gapMax = 3;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(9);
            if (r <= 3) begin
                doPixel(12'($urandom), 4'($urandom));
            end else if (r <= 6) begin
                n = ($urandom_range(15) == 0) ? 256 : $urandom_range(6, 1);
                doBurst(12'($urandom), n, 8'h00, 8'h00, 1'b1);
            end else if (r <= 8 || fillsDone > 0) begin
                do opc = 8'($urandom); while (opc >= 8'h01 && opc <= 8'h03);
                doBad(opc);
            end else begin
                fillsDone++;
                doFill(4'($urandom));
            end
            waitIdle();
            checkQuiet("random");
            checkOutput("random leftover writes", expQ.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
